// File: rtl/barrel_shift_driver.sv
// rtl/barrel_shift_driver.sv - command front-end that drives a 4-bit barrel shifter and queues its results
//
// Purpose: accepts shift commands (single shift or four-step sweep), drives the shifter
//          pins A0..A3 / S0,S1 from registers, waits SETTLE_CYCLES, samples Y0..Y3 and
//          queues {result, shamt, last} in an OUT_DEPTH-entry output FIFO.
// Ports:   clk, rst                          clock, synchronous active-high reset
//          in_valid/in_ready/in_data/in_shamt/in_sweep   command port
//          A0..A3, S0, S1                    registered shifter drive pins
//          Y0..Y3                            shifter outputs
//          out_valid/out_ready/out_data/out_shamt/out_last   result port (FIFO head)
//          busy                              command in progress
module barrel_shift_driver #(
    parameter int SETTLE_CYCLES = 1,
    parameter int OUT_DEPTH     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    input  logic [1:0] in_shamt,
    input  logic       in_sweep,
    output logic       A0,
    output logic       A1,
    output logic       A2,
    output logic       A3,
    output logic       S0,
    output logic       S1,
    input  logic       Y0,
    input  logic       Y1,
    input  logic       Y2,
    input  logic       Y3,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_data,
    output logic [1:0] out_shamt,
    output logic       out_last,
    output logic       busy
);
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int NW = $clog2(OUT_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRIVE   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [3:0]    r_a;
    logic [1:0]    r_s;
    logic          r_sweep;
    logic [CW-1:0] r_cnt;

    logic [6:0]    r_mem [OUT_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [NW-1:0] r_count;
    logic          r_out_valid;

    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_last;
    logic [3:0]    w_y;

    assign w_y      = {Y3, Y2, Y1, Y0};
    assign in_ready = (r_state == ST_IDLE) && !rst;
    assign w_accept = in_valid && in_ready;
    assign w_full   = (r_count >= NW'(OUT_DEPTH));
    assign w_last   = !r_sweep || (r_s == 2'd3);
    assign w_pop    = r_out_valid && out_ready;

    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_next = ST_DRIVE;
            end
            ST_DRIVE: begin
                if (r_cnt == CW'(SETTLE_CYCLES - 1)) w_state_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                // No full-bypass: a pop this cycle does not free a slot for this push.
                if (!w_full) begin
                    w_push       = 1'b1;
                    w_state_next = w_last ? ST_IDLE : ST_DRIVE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_s         <= '0;
            r_sweep     <= 1'b0;
            r_cnt       <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;

            if (r_state == ST_DRIVE && w_state_next == ST_DRIVE) r_cnt <= r_cnt + 1'b1;
            else                                                 r_cnt <= '0;

            if (w_accept) begin
                r_a     <= in_data;
                r_s     <= in_sweep ? 2'd0 : in_shamt;
                r_sweep <= in_sweep;
            end else if (w_push && !w_last) begin
                r_s <= r_s + 2'd1;
            end

            if (w_push) r_wr_ptr <= (r_wr_ptr == PW'(OUT_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= (r_rd_ptr == PW'(OUT_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            r_count <= r_count + NW'(w_push) - NW'(w_pop);

            // An entry becomes visible the cycle after it is written, so the head is
            // always an entry that was already present before this edge.
            r_out_valid <= ((r_count - NW'(w_pop)) != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {w_y, r_s, w_last};
    end

    assign {out_data, out_shamt, out_last} = r_out_valid ? r_mem[r_rd_ptr] : 7'd0;
    assign out_valid = r_out_valid;
    assign busy      = (r_state != ST_IDLE);
    assign {A3, A2, A1, A0} = r_a;
    assign {S1, S0}         = r_s;
endmodule

// File: tb/tb_barrel_shift_driver.sv
// tb/tb_barrel_shift_driver.sv - scoreboard bench for barrel_shift_driver
module tb_barrel_shift_driver;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic       in_valid, in_ready, in_sweep, out_valid, out_ready, out_last, busy;
    logic [3:0] in_data, out_data, y_d;
    logic [1:0] in_shamt, out_shamt;
    logic       a0, a1, a2, a3, s0, s1;

    logic       b_in_valid, b_in_ready, b_in_sweep, b_out_valid, b_out_ready, b_out_last, b_busy;
    logic [3:0] b_in_data, b_out_data, b_y0, b_y1, b_y2;
    logic [1:0] b_in_shamt, b_out_shamt;
    logic       b_a0, b_a1, b_a2, b_a3, b_s0, b_s1;

    logic [6:0] sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [3:0] rot(input logic [3:0] a, input logic [1:0] sh);
        logic [3:0] y;
        for (int i = 0; i < 4; i++) y[i] = a[(i + int'(sh)) % 4];
        return y;
    endfunction

    // Shifter models whose outputs lag the pins by the settle time.
    always @(posedge clk) y_d <= rot({a3, a2, a1, a0}, {s1, s0});
    always @(posedge clk) begin
        b_y0 <= rot({b_a3, b_a2, b_a1, b_a0}, {b_s1, b_s0});
        b_y1 <= b_y0;
        b_y2 <= b_y1;
    end

    barrel_shift_driver #(.SETTLE_CYCLES(1), .OUT_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_shamt(in_shamt), .in_sweep(in_sweep),
        .A0(a0), .A1(a1), .A2(a2), .A3(a3), .S0(s0), .S1(s1),
        .Y0(y_d[0]), .Y1(y_d[1]), .Y2(y_d[2]), .Y3(y_d[3]),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_shamt(out_shamt), .out_last(out_last), .busy(busy)
    );

    barrel_shift_driver #(.SETTLE_CYCLES(3), .OUT_DEPTH(2)) dut3 (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_shamt(b_in_shamt), .in_sweep(b_in_sweep),
        .A0(b_a0), .A1(b_a1), .A2(b_a2), .A3(b_a3), .S0(b_s0), .S1(b_s1),
        .Y0(b_y2[0]), .Y1(b_y2[1]), .Y2(b_y2[2]), .Y3(b_y2[3]),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_shamt(b_out_shamt), .out_last(b_out_last), .busy(b_busy)
    );

    // Stimulus only: presents a command at a negedge, returns at the negedge after the accept edge.
    task automatic send(input logic [3:0] d, input logic [1:0] sh, input logic sw);
        int t;
        in_valid = 1'b1; in_data = d; in_shamt = sh; in_sweep = sw;
        t = 0;
        while (!in_ready && t < 100) begin @(negedge clk); t++; end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_sweep = 1'b0; out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_in_shamt = '0; b_in_sweep = 1'b0; b_out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid, busy, a3, a2, a1, a0, s1, s0} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_state got ready/valid/busy/A/S=%b exp=000000000",
                     {in_ready, out_valid, busy, a3, a2, a1, a0, s1, s0});
        end
        n_checks++;
        if ({out_data, out_shamt, out_last} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got %b exp 0000000", {out_data, out_shamt, out_last});
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready got %b exp 1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [6:0] exp;
        int lat;
        out_ready = 1'b1;
        sb.push_back({4'b0111, 2'd1, 1'b1});
        send(4'b1110, 2'd1, 1'b0);
        lat = 0;
        while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
        n_checks++;
        if (lat !== 3) begin n_fail++; $display("FAIL single_latency got %0d exp 3", lat); end
        exp = sb.pop_front();
        n_checks++;
        if ({out_data, out_shamt, out_last} !== exp) begin
            n_fail++;
            $display("FAIL single_entry got %b exp %b", {out_data, out_shamt, out_last}, exp);
        end
        @(negedge clk);
        n_checks++;
        if ({out_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL single_after got valid/busy=%b exp 00", {out_valid, busy});
        end
    endtask

    task automatic test_sweep();
        logic [6:0] exp;
        int last_c;
        out_ready = 1'b1;
        sb.push_back({4'b1110, 2'd0, 1'b0});
        sb.push_back({4'b0111, 2'd1, 1'b0});
        sb.push_back({4'b1011, 2'd2, 1'b0});
        sb.push_back({4'b1101, 2'd3, 1'b1});
        send(4'b1110, 2'd2, 1'b1);
        last_c = -1;
        for (int c = 0; c < 60 && sb.size() > 0; c++) begin
            if (out_valid && out_ready) begin
                exp = sb.pop_front();
                n_checks++;
                if ({out_data, out_shamt, out_last} !== exp) begin
                    n_fail++;
                    $display("FAIL sweep_entry got %b exp %b", {out_data, out_shamt, out_last}, exp);
                end
                n_checks++;
                if (last_c < 0 && c !== 3) begin
                    n_fail++; $display("FAIL sweep_first_latency got %0d exp 3", c);
                end else if (last_c >= 0 && (c - last_c) !== 2) begin
                    n_fail++; $display("FAIL sweep_spacing got %0d exp 2", c - last_c);
                end
                last_c = c;
            end
            @(negedge clk);
        end
        n_checks++;
        if (sb.size() !== 0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_done got left=%0d valid=%b busy=%b exp 0 0 0", sb.size(), out_valid, busy);
            sb.delete();
        end
    endtask

    task automatic test_stall();
        logic [6:0] exp;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) sb.push_back({rot(4'b1001, 2'(k)), 2'(k), k == 3});
        send(4'b1001, 2'd0, 1'b1);
        repeat (8) @(negedge clk);
        for (int r = 0; r < 2; r++) begin
            n_checks++;
            if ({busy, out_valid, s1, s0, a3, a2, a1, a0} !== 8'b1110_1001) begin
                n_fail++;
                $display("FAIL stall_hold got busy/valid/S/A=%b exp 11101001",
                         {busy, out_valid, s1, s0, a3, a2, a1, a0});
            end
            repeat (3) @(negedge clk);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 60 && sb.size() > 0; c++) begin
            if (out_valid && out_ready) begin
                exp = sb.pop_front();
                n_checks++;
                if ({out_data, out_shamt, out_last} !== exp) begin
                    n_fail++;
                    $display("FAIL stall_drain got %b exp %b", {out_data, out_shamt, out_last}, exp);
                end
            end
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (sb.size() !== 0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_done got left=%0d valid=%b busy=%b exp 0 0 0", sb.size(), out_valid, busy);
            sb.delete();
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp;
        int gap;
        logic acc;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 4'b0101; in_shamt = 2'd2; in_sweep = 1'b0;
        sb.push_back({rot(4'b0101, 2'd2), 2'd2, 1'b1});
        @(posedge clk);
        @(negedge clk);
        in_data = 4'b0011; in_shamt = 2'd3;
        sb.push_back({rot(4'b0011, 2'd3), 2'd3, 1'b1});
        gap = -1;
        for (int c = 0; c < 40 && (sb.size() > 0 || in_valid); c++) begin
            if (busy) begin
                n_checks++;
                if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_busy got %b exp 0", in_ready); end
            end
            if (out_valid && out_ready) begin
                exp = sb.pop_front();
                n_checks++;
                if ({out_data, out_shamt, out_last} !== exp) begin
                    n_fail++;
                    $display("FAIL b2b_entry got %b exp %b", {out_data, out_shamt, out_last}, exp);
                end
            end
            acc = in_valid && in_ready;
            if (acc) gap = c;
            @(negedge clk);
            if (acc) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        n_checks++;
        if (gap !== 2 || sb.size() !== 0) begin
            n_fail++;
            $display("FAIL b2b_second_accept got gap=%0d left=%0d exp gap=2 left=0", gap, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send(4'b1011, 2'd0, 1'b1);
        repeat (10) @(negedge clk);
        n_checks++;
        if ({out_valid, busy} !== 2'b11) begin
            n_fail++; $display("FAIL rstmid_pre got valid/busy=%b exp 11", {out_valid, busy});
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_ready_in_reset got %b exp 0", in_ready); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, busy, a3, a2, a1, a0, s1, s0, in_ready} !== 9'b0000_0000_1) begin
            n_fail++;
            $display("FAIL rstmid_after got valid/busy/A/S/ready=%b exp 000000001",
                     {out_valid, busy, a3, a2, a1, a0, s1, s0, in_ready});
        end
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_dropped got valid=%b exp 0", out_valid); end
        sb.delete();
    endtask

    task automatic test_settle3();
        logic [6:0] exp;
        int lat;
        b_out_ready = 1'b1;
        sb.push_back({4'b0010, 2'd3, 1'b1});
        b_in_valid = 1'b1; b_in_data = 4'b0001; b_in_shamt = 2'd3; b_in_sweep = 1'b0;
        @(posedge clk);
        @(negedge clk);
        b_in_valid = 1'b0;
        lat = 0;
        while (!b_out_valid && lat < 50) begin @(negedge clk); lat++; end
        n_checks++;
        if (lat !== 5) begin n_fail++; $display("FAIL settle3_latency got %0d exp 5", lat); end
        exp = sb.pop_front();
        n_checks++;
        if ({b_out_data, b_out_shamt, b_out_last} !== exp) begin
            n_fail++;
            $display("FAIL settle3_entry got %b exp %b", {b_out_data, b_out_shamt, b_out_last}, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_sweep();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_settle3();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
